// File: rtl/sm_1118_msg_pkg.sv
// Message codes, queue entry layout and queue FSM states shared by controller, queue and transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sm_1118_msg_pkg;

  // Message type codes; 0 is never a legal message.
  localparam logic [1:0] MSG_SI   = 2'd1;
  localparam logic [1:0] MSG_SPIM = 2'd2;
  localparam logic [1:0] MSG_SDM  = 2'd3;

  // Field codes.
  localparam logic [1:0] FIELD_MT = 2'd0;
  localparam logic [1:0] FIELD_PP = 2'd1;
  localparam logic [1:0] FIELD_NG = 2'd2;
  localparam logic [1:0] FIELD_VG = 2'd3;

  // Colour codes: R prints as 'P', B as 'W', G as 'N'; 0 is never legal.
  localparam logic [1:0] COL_R = 2'd1;
  localparam logic [1:0] COL_B = 2'd2;
  localparam logic [1:0] COL_G = 2'd3;

  // One queued message, packed MSB-first as {type, field, node, color}.
  typedef struct packed {
    logic [1:0] msg_type;
    logic [1:0] field;
    logic [1:0] node;
    logic [1:0] color;
  } msg_entry_t;

  localparam int ENTRY_W = $bits(msg_entry_t);

  // Queue sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } q_state_e;

  // A request is usable only when type, node and colour are all non-zero.
  function automatic logic req_is_legal(input msg_entry_t e);
    return (e.msg_type != 2'd0) && (e.node != 2'd0) && (e.color != 2'd0);
  endfunction

endpackage

// File: rtl/sm_msg_fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH, with occupancy count.
// Latency: a pushed word is visible at rdata_o the cycle after the push; head read is combinational.
// Backpressure: caller must not push when full_o or pop when empty_o; full/empty come from registered pointers.
module sm_msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == CNT_FULL);
  assign empty_o = (count_o == '0);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sm_msg_queue.sv
// Buffers controller message requests and hands them one at a time to the UART transmitter.
// Latency: request accepted at edge N into an idle empty queue -> tx_start high after edge N+2.
// Backpressure: req_ready low when full; illegal or overflowing requests are dropped with a one-cycle pulse.
module sm_msg_queue
  import sm_1118_msg_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 434,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_type,
  input  logic [1:0] req_field,
  input  logic [1:0] req_node,
  input  logic [1:0] req_color,
  output logic       req_ready,
  output logic [1:0] msg_type,
  output logic [1:0] field,
  output logic [1:0] node_si,
  output logic [1:0] color,
  output logic       tx_start,
  input  logic       tx_complete,
  output logic       busy,
  output logic       overflow,
  output logic       bad_req,
  output logic       timeout
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  msg_entry_t    req_ent;
  logic          req_legal;
  logic          push;
  logic          pop;
  msg_entry_t    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  q_state_e       state_q, state_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           tx_start_q, tx_start_d;
  msg_entry_t     out_q, out_d;
  logic           timeout_q, timeout_d;
  logic           bad_req_q, bad_req_d;
  logic           overflow_q, overflow_d;

  assign req_ent   = '{msg_type: req_type, field: req_field, node: req_node, color: req_color};
  assign req_legal = req_is_legal(req_ent);

  // Legality is judged before fullness, so a bad request never reports overflow.
  always_comb begin
    bad_req_d  = req_valid && !req_legal;
    overflow_d = req_valid && req_legal && fifo_full;
    push       = req_valid && req_legal && !fifo_full;
  end

  sm_msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_50M),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (req_ent),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Sequencer: pop into output regs, settle one cycle, hold tx_start until done or watchdog, then idle gap.
  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    gap_d      = gap_q;
    tx_start_d = tx_start_q;
    out_d      = out_q;
    timeout_d  = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          out_d   = fifo_head;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_start_d = 1'b1;
        wdog_d     = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_complete) begin
          tx_start_d = 1'b0;
          gap_d      = '0;
          state_d    = ST_GAP;
        end else if (wdog_q == WD_LAST) begin
          // Aborted message is not retried; the gap still separates it from the next one.
          tx_start_d = 1'b0;
          timeout_d  = 1'b1;
          gap_d      = '0;
          state_d    = ST_GAP;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_start_d = 1'b0;
      end
    endcase
  end

  // State, counters, message outputs and status pulses.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wdog_q     <= '0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      out_q      <= '0;
      timeout_q  <= 1'b0;
      bad_req_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      out_q      <= out_d;
      timeout_q  <= timeout_d;
      bad_req_q  <= bad_req_d;
      overflow_q <= overflow_d;
    end
  end

  assign req_ready = (fifo_count != CNT_FULL);
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign tx_start  = tx_start_q;
  assign msg_type  = out_q.msg_type;
  assign field     = out_q.field;
  assign node_si   = out_q.node;
  assign color     = out_q.color;
  assign timeout   = timeout_q;
  assign bad_req   = bad_req_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sm_msg_queue.sv
// Randomised and directed bench for sm_msg_queue against a timestamp-based queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sm_msg_queue;

  localparam int DEPTH = 4;
  localparam int GAP   = 434;
  localparam int TMO   = 1000;
  localparam int NEVER = 32'h3fff_ffff;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_type, req_field, req_node, req_color;
  logic       req_ready;
  logic [1:0] msg_type, field, node_si, color;
  logic       tx_start;
  logic       tx_complete;
  logic       busy, overflow, bad_req, timeout;

  always #10 clk_50M = ~clk_50M;

  sm_msg_queue #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_type    (req_type),
    .req_field   (req_field),
    .req_node    (req_node),
    .req_color   (req_color),
    .req_ready   (req_ready),
    .msg_type    (msg_type),
    .field       (field),
    .node_si     (node_si),
    .color       (color),
    .tx_start    (tx_start),
    .tx_complete (tx_complete),
    .busy        (busy),
    .overflow    (overflow),
    .bad_req     (bad_req),
    .timeout     (timeout)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: queue contents plus timestamps. free_at is the first edge at which the
  // sender may take a new message; rise_at is the edge after which tx_start goes high.
  bit [7:0] mq[$];
  bit       m_tx     = 1'b0;
  bit [7:0] m_out    = 8'h00;
  bit       m_ovf    = 1'b0;
  bit       m_bad    = 1'b0;
  bit       m_to     = 1'b0;
  int       rise_at  = -1;
  int       free_at  = NEVER;
  int       tc_delay = 1;
  bit       hold_tx  = 1'b0;
  bit       spur_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v, input bit [1:0] t, input bit [1:0] f,
                            input bit [1:0] n, input bit [1:0] c, input bit tc);
    int  pre;
    bit  pop, bad, ovf;
    cyc++;
    m_ovf = 1'b0;
    m_bad = 1'b0;
    m_to  = 1'b0;
    if (rst) begin
      mq.delete();
      m_tx    = 1'b0;
      m_out   = 8'h00;
      rise_at = -1;
      free_at = cyc + 1;
      return;
    end
    pre = mq.size();
    if (m_tx) begin
      if (tc) begin
        m_tx    = 1'b0;
        free_at = cyc + GAP + 1;
      end else if (cyc == rise_at + TMO) begin
        m_tx    = 1'b0;
        m_to    = 1'b1;
        free_at = cyc + GAP + 1;
      end
    end else if (rise_at == cyc) begin
      m_tx = 1'b1;
    end
    pop = (cyc >= free_at) && (pre > 0);
    bad = v && (t == 2'd0 || n == 2'd0 || c == 2'd0);
    ovf = v && !bad && (pre == DEPTH);
    m_bad = bad;
    m_ovf = ovf;
    if (pop) begin
      m_out    = mq.pop_front();
      rise_at  = cyc + 1;
      free_at  = NEVER;
      tc_delay = $urandom_range(1, 40);
    end
    if (v && !bad && !ovf) mq.push_back({t, f, n, c});
  endtask

  task automatic check_outputs();
    bit e_ready, e_busy;
    e_ready = (mq.size() < DEPTH);
    e_busy  = (free_at > cyc + 1) || (mq.size() > 0);
    chk("tx_start", 32'(tx_start), 32'(m_tx));
    chk("msg_out", 32'({msg_type, field, node_si, color}), 32'(m_out));
    chk("flags{rdy,busy,ovf,bad,to}", 32'({req_ready, busy, overflow, bad_req, timeout}),
        32'({e_ready, e_busy, m_ovf, m_bad, m_to}));
  endtask

  task automatic step(input bit rst, input bit v, input bit [1:0] t, input bit [1:0] f,
                      input bit [1:0] n, input bit [1:0] c);
    bit tc;
    tc = 1'b0;
    if (m_tx && !hold_tx && (cyc + 1 - rise_at == tc_delay)) tc = 1'b1;
    else if (!m_tx && spur_en && $urandom_range(0, 39) == 0) tc = 1'b1;
    reset       = rst;
    req_valid   = v;
    req_type    = t;
    req_field   = f;
    req_node    = n;
    req_color   = c;
    tx_complete = tc;
    @(posedge clk_50M);
    model_edge(rst, v, t, f, n, c, tc);
    @(negedge clk_50M);
    check_outputs();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(1'b0, 1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    end
  endtask

  task automatic push_legal();
    step(1'b0, 1'b1, 2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom_range(1, 3)),
         2'($urandom_range(1, 3)));
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (!((free_at <= cyc + 1) && mq.size() == 0) && k < bound) begin
      idle(1);
      k++;
    end
    chk("drain_within_bound", 32'(k < bound), 32'd1);
  endtask

  initial begin
    int k;
    reset = 1'b1; req_valid = 1'b0; tx_complete = 1'b0;
    req_type = 2'd0; req_field = 2'd0; req_node = 2'd0; req_color = 2'd0;

    repeat (3) step(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    idle(2);

    // Single SI request into an idle block.
    step(1'b0, 1'b1, 2'd1, 2'd3, 2'd1, 2'd2);
    drain(3000);

    // Burst of six: first pops at once, next four fill the FIFO, sixth overflows.
    for (int i = 0; i < 6; i++) push_legal();
    drain(6000);

    // Illegal requests while full: bad_req wins over overflow.
    hold_tx = 1'b1;
    for (int i = 0; i < 5; i++) push_legal();
    idle(3);
    step(1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
    step(1'b0, 1'b1, 2'd2, 2'd1, 2'd0, 2'd3);
    step(1'b0, 1'b1, 2'd3, 2'd1, 2'd2, 2'd0);
    step(1'b0, 1'b1, 2'd3, 2'd2, 2'd1, 2'd1);
    hold_tx = 1'b0;
    drain(10000);

    // Watchdog abort, then the queued message goes out after the gap.
    hold_tx = 1'b1;
    push_legal();
    push_legal();
    idle(1010);
    hold_tx = 1'b0;
    drain(4000);

    // Reset during SEND with three queued.
    hold_tx = 1'b1;
    for (int i = 0; i < 4; i++) push_legal();
    idle(20);
    step(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    hold_tx = 1'b0;
    idle(5);
    drain(100);

    // Push on the very edge at which IDLE pops the last queued entry.
    push_legal();
    push_legal();
    k = 0;
    while (!(mq.size() == 1 && free_at == cyc + 1) && k < 3000) begin
      idle(1);
      k++;
    end
    chk("pop_edge_reached", 32'(k < 3000), 32'd1);
    push_legal();
    drain(3000);

    // Random traffic: illegal fields, spurious tx_complete, occasional reset.
    spur_en = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 4999) == 0) begin
        step(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      end else if ($urandom_range(0, 59) == 0) begin
        step(1'b0, 1'b1, 2'($urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 3)), 2'($urandom),
             2'($urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 3)),
             2'($urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 3)));
      end else begin
        idle(1);
      end
    end
    spur_en = 1'b0;
    drain(8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
